// File: rtl/oneapi_axs_to_avs_pixel_gasket.sv
// AXI4-Stream to Avalon-ST pixel ingress gasket: channel unpacking, SOF/EOL mapping, pre-SOF discard, 2-entry skid buffer.
// Optional statistics counters are enabled with `define ONEAPI_AXS_TO_AVS_STATS_EN.
module oneapi_axs_to_avs_pixel_gasket #(
    parameter int PARALLEL_PIXELS     = 4,
    parameter int BITS_PER_CHANNEL    = 10,
    parameter int CHANNELS            = 4,
    parameter int BITS_PER_CHANNEL_AV = 1 << $clog2(BITS_PER_CHANNEL),
    parameter int BITS_PER_PIXEL_AV   = BITS_PER_CHANNEL_AV * CHANNELS,
    parameter int BITS_AV             = BITS_PER_PIXEL_AV * PARALLEL_PIXELS,
    parameter int EMPTY_BITS          = $clog2(BITS_AV / 8),
    parameter int BITS_PER_PIXEL_AXI  = 8 * ((CHANNELS * BITS_PER_CHANNEL + 7) / 8),
    parameter int BITS_AXI            = BITS_PER_PIXEL_AXI * PARALLEL_PIXELS,
    parameter int TUSER_BITS          = (BITS_AXI + 7) / 8
) (
    input  logic                  csi_clk,
    input  logic                  rsi_reset,
    output logic                  axs_tready,
    input  logic                  axs_tvalid,
    input  logic [BITS_AXI-1:0]   axs_tdata,
    input  logic                  axs_tlast,
    input  logic [TUSER_BITS-1:0] axs_tuser,
    input  logic                  aso_ready,
    output logic                  aso_valid,
    output logic [BITS_AV-1:0]    aso_data,
    output logic                  aso_startofpacket,
    output logic                  aso_endofpacket,
`ifdef ONEAPI_AXS_TO_AVS_STATS_EN
    output logic [31:0]           stat_frames,
    output logic [31:0]           stat_lines,
    output logic [15:0]           stat_dropped,
`endif
    output logic [EMPTY_BITS-1:0] aso_empty
);

    typedef enum logic {WAIT_SOF, STREAM} state_t;

    typedef struct packed {
        logic [BITS_AV-1:0] data;
        logic               sop;
        logic               eop;
    } beat_t;

    state_t state_q, state_d;
    beat_t  in_beat, out_q, skid_q;
    logic   out_valid_q, skid_valid_q, skid_valid_d, tready_q;
    logic   accept, enq, drop, out_free;

    // Pad bits and tuser[TUSER_BITS-1:1] carry nothing for the kernel.
    logic unused_bits;
    assign unused_bits = ^{axs_tuser, axs_tdata};

    // NOTE: every always_comb output gets a default before any conditional write, so no latch is inferred.
    always_comb begin
        in_beat.data = '0;
        for (int p = 0; p < PARALLEL_PIXELS; p++) begin
            for (int c = 0; c < CHANNELS; c++) begin
                in_beat.data[p*BITS_PER_PIXEL_AV + c*BITS_PER_CHANNEL_AV +: BITS_PER_CHANNEL] =
                    axs_tdata[p*BITS_PER_PIXEL_AXI + c*BITS_PER_CHANNEL +: BITS_PER_CHANNEL];
            end
        end
        in_beat.sop = axs_tuser[0];
        in_beat.eop = axs_tlast;
    end

    assign accept   = axs_tvalid && tready_q;
    assign enq      = accept && ((state_q == STREAM) || axs_tuser[0]);
    assign drop     = accept && !enq;
    assign out_free = !out_valid_q || aso_ready;
    // tready is low exactly while the skid holds a beat, so enq and a full skid never coincide.
    assign skid_valid_d = !out_free && (skid_valid_q || enq);

    always_comb begin
        state_d = state_q;
        if (state_q == WAIT_SOF && enq) begin
            state_d = STREAM;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge csi_clk) begin
        if (rsi_reset) begin
            state_q      <= WAIT_SOF;
            tready_q     <= 1'b0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            // NOTE: the payload registers are reset too because aso_data must read zero out of reset.
            out_q        <= '0;
            skid_q       <= '0;
        end else begin
            state_q      <= state_d;
            tready_q     <= !skid_valid_d;
            skid_valid_q <= skid_valid_d;
            if (out_free) begin
                if (skid_valid_q) begin
                    out_q       <= skid_q;
                    out_valid_q <= 1'b1;
                end else begin
                    out_valid_q <= enq;
                    if (enq) begin
                        out_q <= in_beat;
                    end
                end
            end else if (enq) begin
                skid_q <= in_beat;
            end
        end
    end

    assign axs_tready        = tready_q;
    assign aso_valid         = out_valid_q;
    assign aso_data          = out_q.data;
    assign aso_startofpacket = out_q.sop;
    assign aso_endofpacket   = out_q.eop;
    assign aso_empty         = '0;

`ifdef ONEAPI_AXS_TO_AVS_STATS_EN
    logic [31:0] frames_q, lines_q;
    logic [15:0] dropped_q;

    always_ff @(posedge csi_clk) begin
        if (rsi_reset) begin
            frames_q  <= '0;
            lines_q   <= '0;
            dropped_q <= '0;
        end else begin
            if (enq && in_beat.sop) frames_q <= frames_q + 32'd1;
            if (enq && in_beat.eop) lines_q <= lines_q + 32'd1;
            if (drop && dropped_q != 16'hFFFF) dropped_q <= dropped_q + 16'd1;
        end
    end

    assign stat_frames  = frames_q;
    assign stat_lines   = lines_q;
    assign stat_dropped = dropped_q;
`endif

endmodule

// File: tb/tb_oneapi_axs_to_avs_pixel_gasket.sv
// Self-checking bench for oneapi_axs_to_avs_pixel_gasket: directed scenarios plus a randomized stream
// scored against a queue-based model of the gasket's frame/lane rules.
module tb_oneapi_axs_to_avs_pixel_gasket;

    localparam int BA = 256;
    localparam int BX = 160;
    localparam int TU = 20;

    logic          clk = 1'b0;
    logic          rsi_reset = 1'b1;
    logic          axs_tready;
    logic          axs_tvalid = 1'b0;
    logic [BX-1:0] axs_tdata = '0;
    logic          axs_tlast = 1'b0;
    logic [TU-1:0] axs_tuser = '0;
    logic          aso_ready = 1'b1;
    logic          aso_valid;
    logic [BA-1:0] aso_data;
    logic          aso_startofpacket;
    logic          aso_endofpacket;
    logic [4:0]    aso_empty;
`ifdef ONEAPI_AXS_TO_AVS_STATS_EN
    logic [31:0]   stat_frames, stat_lines;
    logic [15:0]   stat_dropped;
`endif

    oneapi_axs_to_avs_pixel_gasket dut (
        .csi_clk           (clk),
        .rsi_reset         (rsi_reset),
        .axs_tready        (axs_tready),
        .axs_tvalid        (axs_tvalid),
        .axs_tdata         (axs_tdata),
        .axs_tlast         (axs_tlast),
        .axs_tuser         (axs_tuser),
        .aso_ready         (aso_ready),
        .aso_valid         (aso_valid),
        .aso_data          (aso_data),
        .aso_startofpacket (aso_startofpacket),
        .aso_endofpacket   (aso_endofpacket),
`ifdef ONEAPI_AXS_TO_AVS_STATS_EN
        .stat_frames       (stat_frames),
        .stat_lines        (stat_lines),
        .stat_dropped      (stat_dropped),
`endif
        .aso_empty         (aso_empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [BX-1:0] d;
        logic          sof;
        logic          eol;
        int            cyc;
    } axi_rec_t;

    typedef struct {
        logic [BA-1:0] d;
        logic          sop;
        logic          eop;
        int            cyc;
    } av_rec_t;

    axi_rec_t acc_log[$];
    av_rec_t  out_log[$];
    av_rec_t  exp_log[$];
    int       exp_dropped;
    int       checks = 0;
    int       failures = 0;
    int       cyc = 0;
    int       stab_err = 0;
    bit       stall_pending = 0;
    av_rec_t  held;

    always @(posedge clk) cyc <= cyc + 1;

    // Records handshakes that complete on the following rising edge, and flags unstable stalled outputs.
    always @(negedge clk) begin
        if (rsi_reset) begin
            stall_pending = 0;
        end else begin
            if (stall_pending && (!aso_valid || aso_data !== held.d ||
                                  aso_startofpacket !== held.sop || aso_endofpacket !== held.eop))
                stab_err++;
            if (axs_tvalid && axs_tready)
                acc_log.push_back('{axs_tdata, axs_tuser[0], axs_tlast, cyc});
            if (aso_valid && aso_ready)
                out_log.push_back('{aso_data, aso_startofpacket, aso_endofpacket, cyc});
            stall_pending = aso_valid && !aso_ready;
            held = '{aso_data, aso_startofpacket, aso_endofpacket, cyc};
        end
    end

    // Each 10-bit channel lands zero-extended in its own 16-bit lane; pad bits vanish.
    function automatic logic [BA-1:0] map_pixels(logic [BX-1:0] d);
        logic [BA-1:0] r = '0;
        for (int p = 0; p < 4; p++)
            for (int c = 0; c < 4; c++)
                r = r | (BA'((d >> (p*40 + c*10)) & BX'(10'h3FF)) << (p*64 + c*16));
        return r;
    endfunction

    function automatic void build_model();
        bit started = 0;
        exp_log.delete();
        exp_dropped = 0;
        foreach (acc_log[i]) begin
            if (!started && !acc_log[i].sof) begin
                exp_dropped++;
            end else begin
                started = 1;
                exp_log.push_back('{map_pixels(acc_log[i].d), acc_log[i].sof, acc_log[i].eol, 0});
            end
        end
    endfunction

    function automatic int sb_errors();
        int e = 0;
        if (out_log.size() != exp_log.size()) e++;
        for (int i = 0; i < out_log.size() && i < exp_log.size(); i++) begin
            if (out_log[i].d !== exp_log[i].d || out_log[i].sop !== exp_log[i].sop ||
                out_log[i].eop !== exp_log[i].eop) begin
                e++;
                $display("scoreboard beat %0d got %h/%b/%b want %h/%b/%b", i, out_log[i].d,
                         out_log[i].sop, out_log[i].eop, exp_log[i].d, exp_log[i].sop, exp_log[i].eop);
            end
        end
        return e;
    endfunction

    function automatic logic [BX-1:0] rand_data();
        return {$urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        acc_log.delete();
        out_log.delete();
        stab_err = 0;
    endtask

    task automatic do_reset();
        rsi_reset  = 1'b1;
        axs_tvalid = 1'b0;
        aso_ready  = 1'b1;
        tick();
        tick();
        rsi_reset = 1'b0;
        clear_logs();
        tick();
    endtask

    task automatic send_beat(input logic [BX-1:0] d, input logic sof, input logic eol);
        bit done = 0;
        axs_tvalid   = 1'b1;
        axs_tdata    = d;
        axs_tuser    = TU'($urandom);
        axs_tuser[0] = sof;
        axs_tlast    = eol;
        for (int i = 0; i < 50 && !done; i++) begin
            done = axs_tready;
            tick();
        end
        axs_tvalid = 1'b0;
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL send_timeout: tready never seen high within 50 cycles");
        end
    endtask

    task automatic drain();
        aso_ready  = 1'b1;
        axs_tvalid = 1'b0;
        build_model();
        for (int i = 0; i < 100 && out_log.size() < exp_log.size(); i++) tick();
        tick();
        tick();
    endtask

    task automatic test_reset();
        rsi_reset  = 1'b1;
        axs_tvalid = 1'b1;
        axs_tdata  = rand_data();
        axs_tuser  = '1;
        aso_ready  = 1'b0;
        tick();
        tick();
        checks++; if (axs_tready !== 1'b0) begin failures++; $display("FAIL reset_tready: got %b want 0", axs_tready); end
        checks++; if (aso_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", aso_valid); end
        checks++; if (aso_data !== '0) begin failures++; $display("FAIL reset_data: got %h want 0", aso_data); end
        checks++; if ({aso_startofpacket, aso_endofpacket} !== 2'b00) begin failures++; $display("FAIL reset_sop_eop: got %b%b want 00", aso_startofpacket, aso_endofpacket); end
        checks++; if (aso_empty !== 5'd0) begin failures++; $display("FAIL reset_empty: got %0d want 0", aso_empty); end
`ifdef ONEAPI_AXS_TO_AVS_STATS_EN
        checks++; if ({stat_frames, stat_lines, 16'(stat_dropped)} !== '0) begin failures++; $display("FAIL reset_stats: got %0d/%0d/%0d want 0/0/0", stat_frames, stat_lines, stat_dropped); end
`endif
        rsi_reset  = 1'b0;
        axs_tvalid = 1'b0;
        aso_ready  = 1'b1;
        clear_logs();
        tick();
        checks++; if (axs_tready !== 1'b1) begin failures++; $display("FAIL reset_release_tready: got %b want 1", axs_tready); end
    endtask

    task automatic test_data_mapping();
        logic [BX-1:0] d = '0;
        logic [BA-1:0] want = 256'h0044004300420041_0034003300320031_0024002300220021_0014001300120011;
        do_reset();
        for (int p = 0; p < 4; p++)
            for (int c = 0; c < 4; c++)
                d[p*40 + c*10 +: 10] = 10'(16*(p+1) + (c+1));
        send_beat(d, 1'b1, 1'b0);
        checks++; if (aso_valid !== 1'b1) begin failures++; $display("FAIL map_latency_valid: got %b want 1", aso_valid); end
        checks++; if (aso_data !== want) begin failures++; $display("FAIL map_data: got %h want %h", aso_data, want); end
        checks++; if ({aso_startofpacket, aso_endofpacket} !== 2'b10) begin failures++; $display("FAIL map_sop_eop: got %b%b want 10", aso_startofpacket, aso_endofpacket); end
        checks++; if (aso_empty !== 5'd0) begin failures++; $display("FAIL map_empty: got %0d want 0", aso_empty); end
        drain();
        checks++; if (sb_errors() !== 0) begin failures++; $display("FAIL map_scoreboard: got %0d beats want %0d", out_log.size(), exp_log.size()); end
        if (out_log.size() > 0 && acc_log.size() > 0) begin
            checks++; if (out_log[0].cyc - acc_log[0].cyc !== 1) begin failures++; $display("FAIL map_latency_cycles: got %0d want 1", out_log[0].cyc - acc_log[0].cyc); end
        end
    endtask

    task automatic test_pre_sof();
        logic [BX-1:0] last_d = rand_data();
        do_reset();
        for (int i = 0; i < 3; i++) send_beat(rand_data(), 1'b0, 1'($urandom));
        send_beat(last_d, 1'b1, 1'b0);
        drain();
        checks++; if (out_log.size() !== 1) begin failures++; $display("FAIL presof_count: got %0d want 1", out_log.size()); end
        else begin
            checks++; if (out_log[0].d !== map_pixels(last_d)) begin failures++; $display("FAIL presof_data: got %h want %h", out_log[0].d, map_pixels(last_d)); end
        end
`ifdef ONEAPI_AXS_TO_AVS_STATS_EN
        checks++; if (stat_dropped !== 16'd3) begin failures++; $display("FAIL presof_dropped: got %0d want 3", stat_dropped); end
        checks++; if (stat_frames !== 32'd1) begin failures++; $display("FAIL presof_frames: got %0d want 1", stat_frames); end
`endif
    endtask

    task automatic test_backpressure();
        logic [BX-1:0] line_d [8];
        int idx = 0;
        int occ;
        bit tr;
        bit saw_low = 0;
        do_reset();
        foreach (line_d[i]) line_d[i] = rand_data();
        for (int k = 0; k < 40 && idx < 8; k++) begin
            aso_ready    = !(k >= 2 && k <= 5);
            axs_tvalid   = 1'b1;
            axs_tdata    = line_d[idx];
            axs_tuser    = '0;
            axs_tuser[0] = (idx == 0);
            axs_tlast    = (idx == 7);
            tr = axs_tready;
            tick();
            if (tr) idx++;
            occ = acc_log.size() - out_log.size();
            if (!axs_tready) saw_low = 1;
            checks++; if (axs_tready !== (occ < 2)) begin failures++; $display("FAIL bp_tready_k%0d: got %b want %b (occupancy %0d)", k, axs_tready, occ < 2, occ); end
        end
        axs_tvalid = 1'b0;
        drain();
        checks++; if (!saw_low) begin failures++; $display("FAIL bp_tready_never_low: got 1 always want a 0"); end
        checks++; if (sb_errors() !== 0) begin failures++; $display("FAIL bp_scoreboard: got %0d beats want %0d", out_log.size(), exp_log.size()); end
        for (int i = 0; i < out_log.size(); i++) begin
            checks++; if (out_log[i].eop !== (i == 7)) begin failures++; $display("FAIL bp_eop_beat%0d: got %b want %b", i, out_log[i].eop, i == 7); end
        end
        checks++; if (stab_err !== 0) begin failures++; $display("FAIL bp_stall_stability: got %0d changes want 0", stab_err); end
    endtask

    task automatic test_full_throughput();
        int idx = 0;
        int bubbles = 0;
        bit tr;
        do_reset();
        aso_ready = 1'b1;
        for (int k = 0; k < 40 && idx < 16; k++) begin
            axs_tvalid   = 1'b1;
            axs_tdata    = rand_data();
            axs_tuser    = '0;
            axs_tuser[0] = (idx == 0);
            axs_tlast    = (idx % 8 == 7);
            tr = axs_tready;
            tick();
            if (tr) idx++;
        end
        axs_tvalid = 1'b0;
        drain();
        checks++; if (out_log.size() !== 16) begin failures++; $display("FAIL tput_count: got %0d want 16", out_log.size()); end
        for (int i = 1; i < out_log.size(); i++)
            if (out_log[i].cyc != out_log[i-1].cyc + 1) bubbles++;
        checks++; if (bubbles !== 0) begin failures++; $display("FAIL tput_bubbles: got %0d want 0", bubbles); end
        checks++; if (sb_errors() !== 0) begin failures++; $display("FAIL tput_scoreboard: got %0d beats want %0d", out_log.size(), exp_log.size()); end
    endtask

    task automatic test_reset_midline();
        do_reset();
        aso_ready = 1'b0;
        send_beat(rand_data(), 1'b1, 1'b0);
        send_beat(rand_data(), 1'b0, 1'b0);
        checks++; if (axs_tready !== 1'b0) begin failures++; $display("FAIL midrst_full_tready: got %b want 0", axs_tready); end
        rsi_reset = 1'b1;
        tick();
        checks++; if (aso_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid: got %b want 0", aso_valid); end
        checks++; if (aso_data !== '0) begin failures++; $display("FAIL midrst_data: got %h want 0", aso_data); end
        rsi_reset = 1'b0;
        clear_logs();
        tick();
        send_beat(rand_data(), 1'b0, 1'b1);
        aso_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        checks++; if (out_log.size() !== 0) begin failures++; $display("FAIL midrst_drop: got %0d beats want 0", out_log.size()); end
`ifdef ONEAPI_AXS_TO_AVS_STATS_EN
        checks++; if (stat_dropped !== 16'd1) begin failures++; $display("FAIL midrst_dropped: got %0d want 1", stat_dropped); end
`endif
    endtask

    task automatic test_pad_masking();
        logic [BA-1:0] want = '0;
        do_reset();
        for (int l = 0; l < 16; l++) want[l*16 +: 16] = 16'h03FF;
        send_beat('1, 1'b1, 1'b1);
        checks++; if (aso_data !== want) begin failures++; $display("FAIL pad_data: got %h want %h", aso_data, want); end
        drain();
        checks++; if (sb_errors() !== 0) begin failures++; $display("FAIL pad_scoreboard: got %0d beats want %0d", out_log.size(), exp_log.size()); end
    endtask

    task automatic test_random();
        bit pend = 0;
        bit tr;
        int nsop = 0;
        int neop = 0;
        do_reset();
        for (int k = 0; k < 400 && (k < 300 || pend); k++) begin
            aso_ready = ($urandom % 3) != 0;
            if (!pend && k < 300 && ($urandom % 4) != 0) begin
                pend         = 1;
                axs_tdata    = rand_data();
                axs_tuser    = TU'($urandom);
                axs_tuser[0] = (k == 12) || (k > 12 && ($urandom % 10) == 0);
                axs_tlast    = ($urandom % 5) == 0;
            end
            axs_tvalid = pend;
            tr = axs_tready;
            tick();
            if (pend && tr) pend = 0;
        end
        drain();
        checks++; if (sb_errors() !== 0) begin failures++; $display("FAIL rand_scoreboard: got %0d beats want %0d", out_log.size(), exp_log.size()); end
        checks++; if (stab_err !== 0) begin failures++; $display("FAIL rand_stall_stability: got %0d changes want 0", stab_err); end
        foreach (exp_log[i]) begin
            nsop += int'(exp_log[i].sop);
            neop += int'(exp_log[i].eop);
        end
`ifdef ONEAPI_AXS_TO_AVS_STATS_EN
        checks++; if (stat_frames !== 32'(nsop)) begin failures++; $display("FAIL rand_frames: got %0d want %0d", stat_frames, nsop); end
        checks++; if (stat_lines !== 32'(neop)) begin failures++; $display("FAIL rand_lines: got %0d want %0d", stat_lines, neop); end
        checks++; if (stat_dropped !== 16'(exp_dropped)) begin failures++; $display("FAIL rand_dropped: got %0d want %0d", stat_dropped, exp_dropped); end
`else
        if (nsop + neop < 0) $display("unreachable");
`endif
    endtask

    initial begin
        test_reset();
        test_data_mapping();
        test_pre_sof();
        test_backpressure();
        test_full_throughput();
        test_reset_midline();
        test_pad_masking();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
